// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings and defaults for the memory port arbiter
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_MEM  = 2'd2
    } owner_e;

    localparam int FAIR_LIMIT_DEFAULT = 4;
    localparam int FAIR_CW            = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - IF/MEM request side and backing-memory side of the arbiter
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req_i;
    logic [AW-1:0] if_addr_i;
    logic          if_flush_i;
    logic [DW-1:0] if_rdata_o;
    logic          if_valid_o;
    logic          if_stall_o;

    logic          mem_req_i;
    logic          mem_we_i;
    logic [AW-1:0] mem_addr_i;
    logic [DW-1:0] mem_wdata_i;
    logic [DW-1:0] mem_rdata_o;
    logic          mem_valid_o;
    logic          mem_stall_o;

    logic          bus_req_o;
    logic          bus_we_o;
    logic [AW-1:0] bus_addr_o;
    logic [DW-1:0] bus_wdata_o;
    logic          bus_gnt_i;
    logic          bus_rvalid_i;
    logic [DW-1:0] bus_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i, if_flush_i,
        output if_rdata_o, if_valid_o, if_stall_o,
        input  mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i,
        output mem_rdata_o, mem_valid_o, mem_stall_o,
        output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o,
        input  bus_gnt_i, bus_rvalid_i, bus_rdata_i
    );

    modport master (
        output if_req_i, if_addr_i, if_flush_i,
        input  if_rdata_o, if_valid_o, if_stall_o,
        output mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i,
        input  mem_rdata_o, mem_valid_o, mem_stall_o,
        input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o,
        output bus_gnt_i, bus_rvalid_i, bus_rdata_i
    );
endinterface

// File: rtl/mem_port_fair_ctr.sv
// rtl/mem_port_fair_ctr.sv - saturating count of MEM grants that bypassed a waiting fetch
module mem_port_fair_ctr
    import mem_port_arbiter_pkg::*;
#(
    parameter int FAIR_LIMIT = FAIR_LIMIT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_grant,
    input  logic if_grant,
    input  logic if_pending,
    output logic force_if
);
    localparam logic [FAIR_CW-1:0] LIMIT = FAIR_CW'(FAIR_LIMIT);

    logic [FAIR_CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (if_grant) begin
            cnt_q <= '0;
        end else if (mem_grant && if_pending && cnt_q != LIMIT) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign force_if = (cnt_q == LIMIT);
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between instruction fetch and load/store
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int FAIR_LIMIT = FAIR_LIMIT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave port
);
    state_e        state_q, state_d;
    owner_e        owner_q, owner_d;
    logic          drop_q, drop_d;
    logic          bus_req_q, bus_req_d;
    logic          bus_we_q, bus_we_d;
    logic [AW-1:0] bus_addr_q, bus_addr_d;
    logic [DW-1:0] bus_wdata_q, bus_wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] mem_rdata_q, mem_rdata_d;
    logic          if_valid_q, if_valid_d;
    logic          mem_valid_q, mem_valid_d;

    logic if_pend, mem_pend, if_grant, mem_grant, force_if, if_flush_hit;

    // A requester whose valid is pulsing this cycle is still holding the request just served.
    assign if_pend      = port.if_req_i & ~if_valid_q;
    assign mem_pend     = port.mem_req_i & ~mem_valid_q;
    assign if_flush_hit = port.if_flush_i & (owner_q == OWN_IF);

    mem_port_fair_ctr #(.FAIR_LIMIT(FAIR_LIMIT)) u_fair (
        .clk        (clk),
        .rst        (rst),
        .mem_grant  (mem_grant),
        .if_grant   (if_grant),
        .if_pending (if_pend),
        .force_if   (force_if)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        drop_d      = drop_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_valid_d  = 1'b0;
        mem_valid_d = 1'b0;
        if_grant    = 1'b0;
        mem_grant   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (if_pend && (force_if || !mem_pend)) begin
                    if_grant    = 1'b1;
                    state_d     = ST_ISSUE;
                    owner_d     = OWN_IF;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = port.if_addr_i;
                    bus_wdata_d = '0;
                end else if (mem_pend) begin
                    mem_grant   = 1'b1;
                    state_d     = ST_ISSUE;
                    owner_d     = OWN_MEM;
                    bus_req_d   = 1'b1;
                    bus_we_d    = port.mem_we_i;
                    bus_addr_d  = port.mem_addr_i;
                    bus_wdata_d = port.mem_wdata_i;
                end
            end
            ST_ISSUE: begin
                if (if_flush_hit) drop_d = 1'b1;
                if (port.bus_gnt_i) begin
                    state_d   = ST_WAIT;
                    bus_req_d = 1'b0;
                end
            end
            ST_WAIT: begin
                if (port.bus_rvalid_i) begin
                    state_d = ST_IDLE;
                    owner_d = OWN_NONE;
                    drop_d  = 1'b0;
                    if (owner_q == OWN_IF) begin
                        if (!drop_q && !port.if_flush_i) begin
                            if_rdata_d = port.bus_rdata_i;
                            if_valid_d = 1'b1;
                        end
                    end else begin
                        mem_valid_d = 1'b1;
                        if (!bus_we_q) mem_rdata_d = port.bus_rdata_i;
                    end
                end else if (if_flush_hit) begin
                    drop_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_NONE;
            drop_q      <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_valid_q  <= 1'b0;
            mem_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            drop_q      <= drop_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_valid_q  <= if_valid_d;
            mem_valid_q <= mem_valid_d;
        end
    end

    // Stalls are gated by reset so every output reads 0 while rst is low.
    assign port.if_stall_o  = rst & port.if_req_i & ~if_valid_q;
    assign port.mem_stall_o = rst & port.mem_req_i & ~mem_valid_q;
    assign port.if_rdata_o  = if_rdata_q;
    assign port.if_valid_o  = if_valid_q;
    assign port.mem_rdata_o = mem_rdata_q;
    assign port.mem_valid_o = mem_valid_q;
    assign port.bus_req_o   = bus_req_q;
    assign port.bus_we_o    = bus_we_q;
    assign port.bus_addr_o  = bus_addr_q;
    assign port.bus_wdata_o = bus_wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(32), .DW(32)) p ();

    mem_port_arbiter #(.AW(32), .DW(32), .FAIR_LIMIT(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .port (p)
    );

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        p.if_req_i = 0; p.if_addr_i = '0; p.if_flush_i = 0;
        p.mem_req_i = 0; p.mem_we_i = 0; p.mem_addr_i = '0; p.mem_wdata_i = '0;
        p.bus_gnt_i = 0; p.bus_rvalid_i = 0; p.bus_rdata_i = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 0;
        repeat (2) nxt();
        #1;
        n_chk++; if ({p.if_valid_o, p.mem_valid_o, p.if_stall_o, p.mem_stall_o, p.bus_req_o, p.bus_we_o} !== 6'b0)
            $display("FAIL reset_ctrl: got %b exp 000000", {p.if_valid_o, p.mem_valid_o, p.if_stall_o, p.mem_stall_o, p.bus_req_o, p.bus_we_o}); else n_pass++;
        n_chk++; if ({p.if_rdata_o, p.mem_rdata_o, p.bus_addr_o, p.bus_wdata_o} !== 128'b0)
            $display("FAIL reset_data: got %h exp 0", {p.if_rdata_o, p.mem_rdata_o, p.bus_addr_o, p.bus_wdata_o}); else n_pass++;
        nxt();
        rst = 1;
    endtask

    task automatic test_lone_fetch();
        nxt(); p.if_req_i = 1; p.if_addr_i = 32'h40; #1;
        n_chk++; if (p.if_stall_o !== 1'b1) $display("FAIL lone_stall_c0: got %b exp 1", p.if_stall_o); else n_pass++;
        nxt(); #1;
        n_chk++; if ({p.bus_req_o, p.bus_we_o, p.bus_addr_o} !== {2'b10, 32'h40})
            $display("FAIL lone_bus_c1: got %b%b %h exp 10 00000040", p.bus_req_o, p.bus_we_o, p.bus_addr_o); else n_pass++;
        n_chk++; if (p.if_stall_o !== 1'b1) $display("FAIL lone_stall_c1: got %b exp 1", p.if_stall_o); else n_pass++;
        p.bus_gnt_i = 1;
        nxt(); p.bus_gnt_i = 0; #1;
        n_chk++; if ({p.bus_req_o, p.if_stall_o, p.if_valid_o} !== 3'b010)
            $display("FAIL lone_c2: got %b exp 010", {p.bus_req_o, p.if_stall_o, p.if_valid_o}); else n_pass++;
        p.bus_rvalid_i = 1; p.bus_rdata_i = 32'h2008_0005;
        nxt(); p.bus_rvalid_i = 0; #1;
        n_chk++; if ({p.if_valid_o, p.if_stall_o, p.if_rdata_o} !== {2'b10, 32'h2008_0005})
            $display("FAIL lone_c3: got %b%b %h exp 10 20080005", p.if_valid_o, p.if_stall_o, p.if_rdata_o); else n_pass++;
        p.if_req_i = 0;
        nxt(); #1;
        n_chk++; if ({p.if_valid_o, p.bus_req_o} !== 2'b00)
            $display("FAIL lone_c4: got %b exp 00", {p.if_valid_o, p.bus_req_o}); else n_pass++;
    endtask

    task automatic test_simultaneous();
        nxt(); p.if_req_i = 1; p.if_addr_i = 32'h44; p.mem_req_i = 1; p.mem_we_i = 0; p.mem_addr_i = 32'h100;
        nxt(); #1;
        n_chk++; if ({p.bus_req_o, p.bus_we_o, p.bus_addr_o} !== {2'b10, 32'h100})
            $display("FAIL simul_mem_first: got %b%b %h exp 10 00000100", p.bus_req_o, p.bus_we_o, p.bus_addr_o); else n_pass++;
        p.bus_gnt_i = 1;
        nxt(); p.bus_gnt_i = 0; p.bus_rvalid_i = 1; p.bus_rdata_i = 32'hDEAD_BEEF;
        nxt(); p.bus_rvalid_i = 0; #1;
        n_chk++; if ({p.mem_valid_o, p.if_valid_o, p.bus_req_o, p.mem_rdata_o} !== {3'b100, 32'hDEAD_BEEF})
            $display("FAIL simul_mem_done: got %b%b%b %h exp 100 deadbeef", p.mem_valid_o, p.if_valid_o, p.bus_req_o, p.mem_rdata_o); else n_pass++;
        p.mem_req_i = 0;
        nxt(); #1;
        n_chk++; if ({p.bus_req_o, p.bus_addr_o} !== {1'b1, 32'h44})
            $display("FAIL simul_if_second: got %b %h exp 1 00000044", p.bus_req_o, p.bus_addr_o); else n_pass++;
        p.bus_gnt_i = 1;
        nxt(); p.bus_gnt_i = 0; p.bus_rvalid_i = 1; p.bus_rdata_i = 32'h1111_2222;
        nxt(); p.bus_rvalid_i = 0; #1;
        n_chk++; if ({p.if_valid_o, p.if_rdata_o} !== {1'b1, 32'h1111_2222})
            $display("FAIL simul_if_done: got %b %h exp 1 11112222", p.if_valid_o, p.if_rdata_o); else n_pass++;
        p.if_req_i = 0;
    endtask

    task automatic test_store_delayed_gnt();
        nxt(); p.mem_req_i = 1; p.mem_we_i = 1; p.mem_addr_i = 32'h10; p.mem_wdata_i = 32'h1234;
        for (int i = 0; i < 4; i++) begin
            nxt(); #1;
            n_chk++; if ({p.bus_req_o, p.bus_we_o, p.bus_addr_o, p.bus_wdata_o} !== {2'b11, 32'h10, 32'h1234})
                $display("FAIL store_hold_%0d: got %b%b %h %h exp 11 00000010 00001234", i, p.bus_req_o, p.bus_we_o, p.bus_addr_o, p.bus_wdata_o); else n_pass++;
            if (i == 3) p.bus_gnt_i = 1;
        end
        nxt(); p.bus_gnt_i = 0; #1;
        n_chk++; if ({p.bus_req_o, p.mem_valid_o, p.mem_stall_o} !== 3'b001)
            $display("FAIL store_wait: got %b exp 001", {p.bus_req_o, p.mem_valid_o, p.mem_stall_o}); else n_pass++;
        p.bus_rvalid_i = 1; p.bus_rdata_i = 32'h5555_AAAA;
        nxt(); p.bus_rvalid_i = 0; #1;
        n_chk++; if ({p.mem_valid_o, p.mem_stall_o, p.mem_rdata_o} !== {2'b10, 32'hDEAD_BEEF})
            $display("FAIL store_ack: got %b%b %h exp 10 deadbeef", p.mem_valid_o, p.mem_stall_o, p.mem_rdata_o); else n_pass++;
        p.mem_req_i = 0; p.mem_we_i = 0;
        nxt(); #1;
        n_chk++; if ({p.mem_valid_o, p.bus_req_o} !== 2'b00)
            $display("FAIL store_single_pulse: got %b exp 00", {p.mem_valid_o, p.bus_req_o}); else n_pass++;
    endtask

    task automatic test_flush();
        nxt(); p.if_req_i = 1; p.if_addr_i = 32'h80;
        nxt(); #1;
        n_chk++; if (p.bus_addr_o !== 32'h80) $display("FAIL flush_issue: got %h exp 00000080", p.bus_addr_o); else n_pass++;
        p.bus_gnt_i = 1;
        nxt(); p.bus_gnt_i = 0; p.if_flush_i = 1;
        nxt(); p.if_flush_i = 0; p.if_addr_i = 32'h200; p.bus_rvalid_i = 1; p.bus_rdata_i = 32'hFFFF_FFFF;
        nxt(); p.bus_rvalid_i = 0; #1;
        n_chk++; if ({p.if_valid_o, p.if_rdata_o} !== {1'b0, 32'h1111_2222})
            $display("FAIL flush_dropped: got %b %h exp 0 11112222", p.if_valid_o, p.if_rdata_o); else n_pass++;
        nxt(); #1;
        n_chk++; if ({p.bus_req_o, p.bus_addr_o} !== {1'b1, 32'h200})
            $display("FAIL flush_refetch: got %b %h exp 1 00000200", p.bus_req_o, p.bus_addr_o); else n_pass++;
        p.bus_gnt_i = 1;
        nxt(); p.bus_gnt_i = 0; p.bus_rvalid_i = 1; p.bus_rdata_i = 32'hCAFE_0001;
        nxt(); p.bus_rvalid_i = 0; #1;
        n_chk++; if ({p.if_valid_o, p.if_rdata_o} !== {1'b1, 32'hCAFE_0001})
            $display("FAIL flush_refetch_done: got %b %h exp 1 cafe0001", p.if_valid_o, p.if_rdata_o); else n_pass++;
        p.if_req_i = 0;
    endtask

    task automatic test_fairness();
        logic [31:0] exp_addr;
        p.mem_we_i = 0; p.mem_addr_i = 32'h300; p.if_addr_i = 32'h400;
        for (int k = 0; k < 5; k++) begin
            nxt(); p.if_req_i = 1; p.mem_req_i = 1;
            if (k == 4) begin
                n_chk++; if (dut.u_fair.cnt_q !== 4'd4) $display("FAIL fair_cnt_sat: got %0d exp 4", dut.u_fair.cnt_q); else n_pass++;
            end
            exp_addr = (k < 4) ? 32'h300 : 32'h400;
            nxt(); #1;
            n_chk++; if ({p.bus_req_o, p.bus_addr_o} !== {1'b1, exp_addr})
                $display("FAIL fair_grant_%0d: got %b %h exp 1 %h", k, p.bus_req_o, p.bus_addr_o, exp_addr); else n_pass++;
            p.bus_gnt_i = 1;
            nxt(); p.bus_gnt_i = 0; p.bus_rvalid_i = 1; p.bus_rdata_i = 32'(k);
            nxt(); p.bus_rvalid_i = 0; #1;
            if (k < 4) begin
                n_chk++; if ({p.mem_valid_o, p.if_valid_o} !== 2'b10)
                    $display("FAIL fair_mem_done_%0d: got %b exp 10", k, {p.mem_valid_o, p.if_valid_o}); else n_pass++;
                p.if_req_i = 0;
            end else begin
                n_chk++; if ({p.if_valid_o, p.if_rdata_o} !== {1'b1, 32'd4})
                    $display("FAIL fair_if_done: got %b %h exp 1 00000004", p.if_valid_o, p.if_rdata_o); else n_pass++;
                n_chk++; if (dut.u_fair.cnt_q !== 4'd0) $display("FAIL fair_cnt_clear: got %0d exp 0", dut.u_fair.cnt_q); else n_pass++;
            end
        end
        p.if_req_i = 0; p.mem_req_i = 0;
        nxt(); nxt();
    endtask

    task automatic test_reset_mid_wait();
        nxt(); p.if_req_i = 1; p.if_addr_i = 32'h500;
        nxt(); p.bus_gnt_i = 1;
        nxt(); p.bus_gnt_i = 0;
        #2 rst = 0;
        #1;
        n_chk++; if ({p.if_valid_o, p.if_stall_o, p.bus_req_o, p.bus_addr_o, p.if_rdata_o, p.mem_rdata_o} !== 99'b0)
            $display("FAIL rst_async: got %b%b%b %h %h %h exp all 0", p.if_valid_o, p.if_stall_o, p.bus_req_o, p.bus_addr_o, p.if_rdata_o, p.mem_rdata_o); else n_pass++;
        nxt(); rst = 1; p.if_addr_i = 32'h600; #1;
        n_chk++; if (p.if_stall_o !== 1'b1) $display("FAIL rst_refetch_stall: got %b exp 1", p.if_stall_o); else n_pass++;
        nxt(); #1;
        n_chk++; if ({p.bus_req_o, p.bus_addr_o} !== {1'b1, 32'h600})
            $display("FAIL rst_refetch_issue: got %b %h exp 1 00000600", p.bus_req_o, p.bus_addr_o); else n_pass++;
        p.bus_gnt_i = 1;
        nxt(); p.bus_gnt_i = 0; p.bus_rvalid_i = 1; p.bus_rdata_i = 32'h0000_600D;
        nxt(); p.bus_rvalid_i = 0; #1;
        n_chk++; if ({p.if_valid_o, p.if_rdata_o} !== {1'b1, 32'h0000_600D})
            $display("FAIL rst_refetch_done: got %b %h exp 1 0000600d", p.if_valid_o, p.if_rdata_o); else n_pass++;
        p.if_req_i = 0;
        nxt();
    endtask

    initial begin
        test_reset();
        test_lone_fetch();
        test_simultaneous();
        test_store_delayed_gnt();
        test_flush();
        test_fairness();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified single-port memory between the IF-stage instruction fetch and the MEM-stage load/store.
- Sequences each access as a single outstanding bus transaction.
- Drives stall signals that the CPU top uses to hold PC, IF/ID and the downstream pipeline registers.
- Sits between the IF/MEM stages and the backing memory; it replaces direct instruction_memory/data_memory access.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- FAIR_LIMIT, 4, number of consecutive MEM grants with IF pending before IF is forced to win (range 1..15).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- if_req_i  in  1  fetch request, held until if_valid_o
- if_addr_i  in  AW  fetch address (PC)
- if_flush_i  in  1  branch redirect; cancels outstanding fetch
- if_rdata_o  out  DW  fetched instruction
- if_valid_o  out  1  one-cycle pulse, if_rdata_o valid
- if_stall_o  out  1  fetch not yet complete
- mem_req_i  in  1  MemRead|MemWrite, held until mem_valid_o
- mem_we_i  in  1  1 = store
- mem_addr_i  in  AW  ALU result address
- mem_wdata_i  in  DW  store data (forwarded rt)
- mem_rdata_o  out  DW  load data
- mem_valid_o  out  1  one-cycle pulse, access complete
- mem_stall_o  out  1  data access not yet complete
- bus_req_o  out  1  memory request valid
- bus_we_o  out  1  write enable
- bus_addr_o  out  AW  address
- bus_wdata_o  out  DW  write data
- bus_gnt_i  in  1  memory accepts request this cycle
- bus_rvalid_i  in  1  response (read data or write ack), exactly one per granted request
- bus_rdata_i  in  DW  read data

Behaviour:
- Reset (rst=0, async): state=IDLE, owner=NONE, drop=0, fair_cnt=0. Every output is 0, including rdata, stalls and bus outputs.
- FSM states:
  - IDLE: arbitrate.
  - ISSUE: bus_req_o=1 with the latched we/addr/wdata; go to WAIT on bus_gnt_i.
  - WAIT: wait for bus_rvalid_i, then go to IDLE.
- Address, data and we are latched on the IDLE->ISSUE transition. The bus outputs come from registers and do not change while in ISSUE.
- Arbitration in IDLE:
  - MEM wins over IF, unless fair_cnt==FAIR_LIMIT and if_req_i=1, in which case IF wins.
  - fair_cnt increments on a MEM grant while if_req_i=1, saturating at FAIR_LIMIT.
  - fair_cnt clears on any IF grant.
- Request consumed rule: in the IDLE cycle where X_valid_o=1, requester X's req is ignored. That req is the one just served; a new request from X is first seen the following cycle.
- Response on bus_rvalid_i in WAIT:
  - bus_rdata_i is registered into the owner's rdata_o.
  - The owner's valid_o pulses the next cycle, when state is already IDLE.
  - Writes also pulse mem_valid_o; mem_rdata_o is unchanged on writes.
- Minimum latency: req in IDLE at cycle 0, bus_req_o at cycle 1, gnt at cycle 1, rvalid at cycle 2, valid_o at cycle 3.
- Stalls are combinational:
  - if_stall_o = if_req_i & ~if_valid_o
  - mem_stall_o = mem_req_i & ~mem_valid_o
- Flush:
  - if_flush_i while owner=IF in ISSUE or WAIT sets drop=1. The bus request is not withdrawn; ISSUE holds until gnt.
  - The response is consumed with no if_valid_o pulse and if_rdata_o unchanged. drop clears on that response.
  - if_flush_i in IDLE, or while owner=MEM, has no effect.
  - Flush and rvalid in the same WAIT cycle: response discarded.
- bus_rvalid_i outside WAIT is ignored. bus_gnt_i outside ISSUE is ignored.
- At most one transaction is outstanding; no request is issued in the IDLE cycle a response returns.
- Reset mid-transaction aborts immediately to reset values. The memory shares rst, so no stale response arrives.

Decomposition:
- Shared cpu_pkg holds:
  - the state encoding: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2
  - the owner encoding: NONE=2'd0, IF=2'd1, MEM=2'd2
  - the FAIR_LIMIT default
- One natural sub-module: mem_port_fair_ctr, the saturating fairness counter with a force_if output. Everything else stays in the FSM.

Test Plan:
- Lone fetch: if_req_i=1, addr=0x0000_0040, gnt immediate, rvalid one cycle later with 0x2008_0005 -> bus_addr_o=0x40 at cycle 1; if_valid_o pulses at cycle 3 with if_rdata_o=0x2008_0005; if_stall_o=1 during cycles 0..2.
- Simultaneous requests: if_req_i=1 (addr 0x44) and a mem load at 0x100 in the same IDLE cycle -> MEM issued first. mem_valid_o returns 0xDEAD_BEEF, and only then is the fetch at 0x44 issued.
- Store with delayed grant: mem_we_i=1, addr 0x10, wdata 0x1234, gnt withheld 3 cycles -> bus_req_o, bus_addr_o and bus_wdata_o stay stable all 3 cycles; one mem_valid_o pulse after the ack; mem_rdata_o unchanged.
- Flush mid-fetch: fetch at 0x80 in WAIT, then if_flush_i=1 -> the returning 0xFFFF_FFFF produces no if_valid_o. The next fetch at 0x200 completes normally.
- Fairness (FAIR_LIMIT=4): mem_req_i held continuously (re-asserted every cycle) with if_req_i=1 -> after 4 MEM grants, the 5th grant goes to IF and fair_cnt returns to 0.
- Reset mid-WAIT: rst=0 asynchronously between clock edges -> all outputs 0 immediately; after rst=1, a fresh fetch completes with 3-cycle latency.
